// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard inputs in, stall/flush controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_uses_rs1_i;
  logic             id_uses_rs2_i;
  logic             ex_valid_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_i;
  logic             ex_redirect_i;
  logic             mdu_start_i;
  logic             mdu_done_i;
  logic             pc_stall_o;
  logic             if_stall_o;
  logic             if_flush_o;
  logic             id_flush_o;
  logic             ex_stall_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_count_o;
  logic             watchdog_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_valid_i, ex_is_load_i, ex_rd_i, ex_redirect_i, mdu_start_i, mdu_done_i,
    input  pc_stall_o, if_stall_o, if_flush_o, id_flush_o, ex_stall_o,
           state_o, stall_count_o, watchdog_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_valid_i, ex_is_load_i, ex_rd_i, ex_redirect_i, mdu_start_i, mdu_done_i,
    output pc_stall_o, if_stall_o, if_flush_o, id_flush_o, ex_stall_o,
           state_o, stall_count_o, watchdog_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// IF/ID/EX hazard controller: load-use bubbles, redirect flush sequencing, MDU hold with watchdog.
// Controls are combinational from state and current inputs; state and counters are registered.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int MW = $clog2(MAX_STALL + 1);
  localparam logic [FW-1:0] FL_START  = FW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);
  localparam logic [FW-1:0] FL_RELOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [MW-1:0] MDU_LIMIT = MW'(MAX_STALL);

  typedef enum logic [1:0] {
    S_RUN         = 2'd0,
    S_LOAD_BUBBLE = 2'd1,
    S_REDIRECT    = 2'd2,
    S_MDU_WAIT    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fl_cnt_q, fl_cnt_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic             wd_q, wd_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lu;
  logic pc_stall, if_stall, if_flush, id_flush, ex_stall;

  assign lu = bus.ex_valid_i & bus.ex_is_load_i & (bus.ex_rd_i != 5'd0) & bus.id_valid_i &
              ((bus.id_uses_rs1_i & (bus.id_rs1_i == bus.ex_rd_i)) |
               (bus.id_uses_rs2_i & (bus.id_rs2_i == bus.ex_rd_i)));

  always_comb begin
    state_d   = state_q;
    fl_cnt_d  = fl_cnt_q;
    mdu_cnt_d = mdu_cnt_q;
    wd_d      = wd_q;
    pc_stall  = 1'b0;
    if_stall  = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_stall  = 1'b0;
    case (state_q)
      S_RUN, S_LOAD_BUBBLE: begin
        if (bus.ex_redirect_i) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = S_REDIRECT;
            fl_cnt_d = FL_START;
          end else begin
            state_d = S_RUN;
          end
        end else if (bus.mdu_start_i) begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          ex_stall  = 1'b1;
          id_flush  = 1'b1;
          state_d   = S_MDU_WAIT;
          mdu_cnt_d = MW'(1);
        end else if ((state_q == S_RUN) && lu) begin
          // EX holds the bubble next cycle, so the same pair must not stall twice
          pc_stall = 1'b1;
          if_stall = 1'b1;
          id_flush = 1'b1;
          state_d  = S_LOAD_BUBBLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_REDIRECT: begin
        if_flush = 1'b1;
        id_flush = 1'b1;
        if (bus.ex_redirect_i) begin
          fl_cnt_d = FL_RELOAD;
        end else if (fl_cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          fl_cnt_d = fl_cnt_q - FW'(1);
        end
      end
      S_MDU_WAIT: begin
        if (bus.mdu_done_i) begin
          state_d = S_RUN;
        end else if (mdu_cnt_q == MDU_LIMIT) begin
          wd_d    = 1'b1;
          state_d = S_RUN;
        end else begin
          pc_stall  = 1'b1;
          if_stall  = 1'b1;
          ex_stall  = 1'b1;
          id_flush  = 1'b1;
          mdu_cnt_d = mdu_cnt_q + MW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Gating with rst keeps controls quiet while reset is held, regardless of inputs
  assign bus.pc_stall_o    = rst & pc_stall;
  assign bus.if_stall_o    = rst & if_stall;
  assign bus.if_flush_o    = rst & if_flush;
  assign bus.id_flush_o    = rst & id_flush;
  assign bus.ex_stall_o    = rst & ex_stall;
  assign bus.state_o       = state_q;
  assign bus.stall_count_o = stall_cnt_q;
  assign bus.watchdog_o    = wd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      fl_cnt_q    <= '0;
      mdu_cnt_q   <= '0;
      wd_q        <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fl_cnt_q  <= fl_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      wd_q      <= wd_d;
      if (pc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a cycle-level
// reference model that tracks remaining flush cycles, MDU wait length and bubble debt.
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MS = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FC), .MAX_STALL(MS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  // reference model
  int m_flush_left;
  bit m_bubble;
  bit m_mdu;
  int m_mdu_cyc;
  bit m_wd;
  int m_stalls;
  int obs_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs;
    bus.id_valid_i    = 1'b0;
    bus.id_rs1_i      = 5'd0;
    bus.id_rs2_i      = 5'd0;
    bus.id_uses_rs1_i = 1'b0;
    bus.id_uses_rs2_i = 1'b0;
    bus.ex_valid_i    = 1'b0;
    bus.ex_is_load_i  = 1'b0;
    bus.ex_rd_i       = 5'd0;
    bus.ex_redirect_i = 1'b0;
    bus.mdu_start_i   = 1'b0;
    bus.mdu_done_i    = 1'b0;
  endtask

  task automatic model_reset;
    m_flush_left = 0;
    m_bubble     = 1'b0;
    m_mdu        = 1'b0;
    m_mdu_cyc    = 0;
    m_wd         = 1'b0;
    m_stalls     = 0;
  endtask

  // Called just after a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick;
    bit lu;
    logic [4:0] ctl;  // {pc_stall, if_stall, if_flush, id_flush, ex_stall}
    int st;
    logic [6:0] e;
    #1;
    check("stall_count", bus.stall_count_o, m_stalls);
    check("watchdog", bus.watchdog_o, m_wd);
    st = m_mdu ? 3 : (m_flush_left > 0 ? 2 : (m_bubble ? 1 : 0));
    lu = bus.ex_valid_i && bus.ex_is_load_i && bus.ex_rd_i != 0 && bus.id_valid_i &&
         ((bus.id_uses_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
          (bus.id_uses_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
    ctl = 5'b00000;
    if (m_mdu) begin
      if (bus.mdu_done_i) m_mdu = 1'b0;
      else if (m_mdu_cyc == MS) begin
        m_mdu = 1'b0;
        m_wd  = 1'b1;
      end else begin
        ctl = 5'b11011;
        m_mdu_cyc++;
      end
    end else if (m_flush_left > 0) begin
      ctl = 5'b00110;
      if (bus.ex_redirect_i) m_flush_left = FC;
      else m_flush_left--;
    end else if (bus.ex_redirect_i) begin
      ctl = 5'b00110;
      m_flush_left = FC - 1;
      m_bubble = 1'b0;
    end else if (bus.mdu_start_i) begin
      ctl = 5'b11011;
      m_mdu = 1'b1;
      m_mdu_cyc = 1;
      m_bubble = 1'b0;
    end else if (!m_bubble && lu) begin
      ctl = 5'b11010;
      m_bubble = 1'b1;
    end else begin
      m_bubble = 1'b0;
    end
    if (ctl[4] && m_stalls < (2 ** CW) - 1) m_stalls++;
    exp_q.push_back({st[1:0], ctl});
    e = exp_q.pop_front();
    check("state", bus.state_o, e[6:5]);
    check("ctl", {bus.pc_stall_o, bus.if_stall_o, bus.if_flush_o, bus.id_flush_o, bus.ex_stall_o}, e[4:0]);
    obs_flush += bus.if_flush_o;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_valid_i    = 1'b1;
    bus.ex_is_load_i  = 1'b1;
    bus.ex_rd_i       = rd;
    bus.id_valid_i    = 1'b1;
    bus.id_rs2_i      = 5'd5;
    bus.id_uses_rs2_i = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // reset release, idle
    do_reset();
    repeat (5) tick();
    check("t1_state", bus.state_o, 0);
    check("t1_count", bus.stall_count_o, 0);

    // load-use, one bubble only
    set_load_use(5'd5);
    #1 check("t2_pc_stall", bus.pc_stall_o, 1);
    tick();
    tick();
    clear_inputs();
    check("t2_count", bus.stall_count_o, 1);
    check("t2_state", bus.state_o, 0);

    // load into x0 never stalls
    do_reset();
    set_load_use(5'd0);
    #1 check("t3_pc_stall", bus.pc_stall_o, 0);
    tick();
    clear_inputs();

    // single redirect, then a redirect arriving mid-flush
    do_reset();
    obs_flush = 0;
    bus.ex_redirect_i = 1'b1;
    tick();
    bus.ex_redirect_i = 1'b0;
    repeat (4) tick();
    check("t4_flush_cycles", obs_flush, FC);
    bus.ex_redirect_i = 1'b1;
    tick();
    tick();
    bus.ex_redirect_i = 1'b0;
    repeat (5) tick();

    // MDU op finishing after 4 stalled cycles
    do_reset();
    bus.mdu_start_i = 1'b1;
    tick();
    bus.mdu_start_i = 1'b0;
    repeat (3) tick();
    bus.mdu_done_i = 1'b1;
    tick();
    bus.mdu_done_i = 1'b0;
    tick();
    check("t5_count", bus.stall_count_o, 4);

    // MDU watchdog
    do_reset();
    bus.mdu_start_i = 1'b1;
    tick();
    bus.mdu_start_i = 1'b0;
    repeat (MS) tick();
    #1;
    check("t6_watchdog", bus.watchdog_o, 1);
    check("t6_state", bus.state_o, 0);
    @(negedge clk);

    // reset in the middle of an MDU wait
    do_reset();
    bus.mdu_start_i = 1'b1;
    tick();
    bus.mdu_start_i = 1'b0;
    repeat (3) tick();
    bus.ex_redirect_i = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("t6_rst_ctl", {bus.pc_stall_o, bus.if_stall_o, bus.if_flush_o, bus.id_flush_o, bus.ex_stall_o}, 0);
    check("t6_rst_state", bus.state_o, 0);
    check("t6_rst_watchdog", bus.watchdog_o, 0);
    check("t6_rst_count", bus.stall_count_o, 0);
    do_reset();

    // randomized traffic
    repeat (600) begin
      bus.id_valid_i    = ($urandom_range(0, 9) < 8);
      bus.id_rs1_i      = 5'($urandom_range(0, 3));
      bus.id_rs2_i      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1_i = 1'($urandom_range(0, 1));
      bus.id_uses_rs2_i = 1'($urandom_range(0, 1));
      bus.ex_valid_i    = ($urandom_range(0, 9) < 8);
      bus.ex_is_load_i  = 1'($urandom_range(0, 1));
      bus.ex_rd_i       = 5'($urandom_range(0, 3));
      bus.ex_redirect_i = ($urandom_range(0, 9) == 0);
      bus.mdu_start_i   = ($urandom_range(0, 11) == 0);
      bus.mdu_done_i    = ($urandom_range(0, 5) == 0);
      tick();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
